// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W         = 16;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  // Halfword accesses must sit on even byte addresses.
  function automatic logic misaligned(input logic [DATA_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Transaction watchdog: cleared on issue, counts while busy, flags the last allowed cycle.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired_c = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one variable-latency memory port,
// data first with a bounded number of back-to-back data grants while fetch waits.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  state_t          state, state_nxt;
  logic [SC_W-1:0] starve_cnt, starve_nxt;
  logic            tmr_clr, tmr_en, expired_c;
  logic            starving, grant_dm, grant_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .expired_c (expired_c)
  );

  assign starving = (STARVE_MAX != 0) && (starve_cnt == SC_W'(STARVE_MAX));

  // Arbitration, issue and completion; everything is held quiet while rst is high.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    if_done    = 1'b0;
    if_rdata   = '0;
    if_err     = 1'b0;
    dm_done    = 1'b0;
    dm_rdata   = '0;
    dm_err     = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (!mem_busy) begin
            grant_dm = dm_req && !(if_req && starving);
            grant_if = if_req && !grant_dm;
          end
          if (grant_dm) begin
            if (if_req && (starve_cnt != SC_W'(STARVE_MAX))) begin
              starve_nxt = starve_cnt + SC_W'(1);
            end
            if (misaligned(dm_addr)) begin
              dm_done = 1'b1;
              dm_err  = 1'b1;
            end else begin
              mem_en    = 1'b1;
              mem_wr    = dm_wr;
              mem_addr  = dm_addr;
              mem_wdata = dm_wdata;
              tmr_clr   = 1'b1;
              state_nxt = DM_BUSY;
            end
          end else if (grant_if) begin
            starve_nxt = '0;
            if (misaligned(if_addr)) begin
              if_done = 1'b1;
              if_err  = 1'b1;
            end else begin
              mem_en    = 1'b1;
              mem_addr  = if_addr;
              tmr_clr   = 1'b1;
              state_nxt = IF_BUSY;
            end
          end
        end
        IF_BUSY: begin
          tmr_en = 1'b1;
          if (mem_done) begin
            if_done   = 1'b1;
            if_rdata  = mem_rdata;
            state_nxt = IDLE;
          end else if (expired_c) begin
            if_done   = 1'b1;
            if_err    = 1'b1;
            state_nxt = IDLE;
          end
        end
        DM_BUSY: begin
          tmr_en = 1'b1;
          if (mem_done) begin
            dm_done   = 1'b1;
            dm_rdata  = dm_wr ? '0 : mem_rdata;
            state_nxt = IDLE;
          end else if (expired_c) begin
            dm_done   = 1'b1;
            dm_err    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: agents push expected responses, a monitor pops them on done.
module tb_mem_arbiter;

  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned TIMEOUT    = 64;
  localparam int          BOUND      = 200;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } iss_t;

  logic        clk, rst;
  logic        if_req, if_done, if_err, if_stall;
  logic [15:0] if_addr, if_rdata;
  logic        dm_req, dm_wr, dm_done, dm_err, dm_stall;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_wr, mem_busy, mem_done;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_if_done = 0;
  int n_dm_done = 0;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  iss_t        iss_log[$];
  logic [15:0] mem_arr[int];
  logic [15:0] dref[int];

  bit mute      = 1'b0;
  bit rand_lat  = 1'b0;
  bit busy_rand = 1'b0;
  int fixed_lat = 1;
  int stray_n   = 0;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .if_err(if_err), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // Background contents of never-written memory words.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], ~a[15:8]} ^ 16'h3C96;
  endfunction

  function automatic logic [15:0] dref_rd(input logic [15:0] a);
    return dref.exists(int'(a)) ? dref[int'(a)] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: latches the access on issue, answers after a latency, can stay silent.
  initial begin : mem_model
    logic        act;
    int          left;
    int          stray_seen;
    logic [15:0] rd;
    act = 1'b0; left = 0; stray_seen = 0; rd = '0;
    mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_done  = 1'b0;
      mem_rdata = '0;
      if (stray_n != stray_seen) begin
        stray_seen = stray_n;
        mem_done   = 1'b1;
        mem_rdata  = 16'hFFFF;
      end else if (act) begin
        left--;
        if (left <= 0) begin
          act       = 1'b0;
          mem_done  = 1'b1;
          mem_rdata = rd;
        end
      end
      mem_busy = busy_rand && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (mem_en) begin
        if (mem_wr) begin
          mem_arr[int'(mem_addr)] = mem_wdata;
          rd = 16'hDEAD;
        end else begin
          rd = mem_arr.exists(int'(mem_addr)) ? mem_arr[int'(mem_addr)] : init_val(mem_addr);
        end
        if (!mute) begin
          act  = 1'b1;
          left = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
        end
      end
    end
  end

  // Monitor: bus invariants every cycle, scoreboard pops on each done pulse.
  initial begin : monitor
    exp_t e;
    iss_t s;
    forever begin
      @(negedge clk);
      check("if_stall", 32'(if_stall), 32'(if_req & ~if_done));
      check("dm_stall", 32'(dm_stall), 32'(dm_req & ~dm_done));
      if (rst) begin
        check("rst_strobes", 32'({if_done, if_err, dm_done, dm_err, mem_en, mem_wr}), 32'd0);
        check("rst_buses", 32'(if_rdata | dm_rdata | mem_addr | mem_wdata), 32'd0);
      end else begin
        check("busy_issue", 32'(mem_en & mem_busy), 32'd0);
        if (mem_en) begin
          s.cyc = cyc; s.wr = mem_wr; s.addr = mem_addr; s.wdata = mem_wdata;
          iss_log.push_back(s);
        end else begin
          check("idle_bus", 32'(mem_addr | mem_wdata) | 32'(mem_wr), 32'd0);
        end
        if (if_done) begin
          n_if_done++;
          if (if_q.size() == 0) check("if_done_unexpected", 32'(if_q.size()), 32'd1);
          else begin
            e = if_q.pop_front();
            check("if_rdata", 32'(if_rdata), 32'(e.rdata));
            check("if_err", 32'(if_err), 32'(e.err));
          end
        end else begin
          check("if_idle_out", 32'(if_rdata) | 32'(if_err), 32'd0);
        end
        if (dm_done) begin
          n_dm_done++;
          if (dm_q.size() == 0) check("dm_done_unexpected", 32'(dm_q.size()), 32'd1);
          else begin
            e = dm_q.pop_front();
            check("dm_rdata", 32'(dm_rdata), 32'(e.rdata));
            check("dm_err", 32'(dm_err), 32'(e.err));
          end
        end else begin
          check("dm_idle_out", 32'(dm_rdata) | 32'(dm_err), 32'd0);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge following done.
  task automatic fetch_xact(input logic [15:0] a, input logic [15:0] xd, input bit xto,
                            input int gap, output int t_start, output int t_done);
    exp_t e;
    int   n;
    repeat (gap) begin @(posedge clk); #1; end
    e.err   = a[0] | xto;
    e.rdata = e.err ? 16'h0000 : xd;
    if_q.push_back(e);
    if_req = 1'b1; if_addr = a;
    t_start = cyc; t_done = -1; n = 0;
    while (t_done < 0 && n < BOUND) begin
      @(negedge clk);
      if (if_done) t_done = cyc;
      n++;
    end
    if (t_done < 0) check("fetch_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = '0;
  endtask

  task automatic dm_xact(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                         input int gap, output int t_start, output int t_done);
    exp_t e;
    int   n;
    repeat (gap) begin @(posedge clk); #1; end
    e.err = a[0];
    e.rdata = '0;
    if (!a[0]) begin
      if (wr) dref[int'(a)] = wd;
      else e.rdata = dref_rd(a);
    end
    dm_q.push_back(e);
    dm_req = 1'b1; dm_wr = wr; dm_addr = a; dm_wdata = wd;
    t_start = cyc; t_done = -1; n = 0;
    while (t_done < 0 && n < BOUND) begin
      @(negedge clk);
      if (dm_done) t_done = cyc;
      n++;
    end
    if (t_done < 0) check("data_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
  endtask

  initial begin : main
    int ts, td, ts_d, td_d, ts_f, td_f, ts2, td2, ts3, td3;
    int n0, nd0, nd, nf, streak;
    logic [15:0] fa, da;
    logic dw;
    bit exp_fetch;

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 16'h0008;
    @(negedge clk);
    check("rst_stall_follows_req", 32'(if_stall), 32'd1);
    check("rst_no_issue", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'({mem_en, if_done, dm_done}), 32'd0);
    @(posedge clk); #1;

    // Lone fetch, three-cycle memory.
    mem_arr[4] = 16'hA5C3;
    fixed_lat = 3;
    n0 = iss_log.size();
    fetch_xact(16'h0004, 16'hA5C3, 1'b0, 0, ts, td);
    check("A_issue_count", 32'(iss_log.size()), 32'(n0 + 1));
    if (iss_log.size() == n0 + 1) begin
      check("A_issue_cyc", 32'(iss_log[n0].cyc), 32'(ts));
      check("A_issue_addr", 32'(iss_log[n0].addr), 32'h0004);
      check("A_issue_wr", 32'(iss_log[n0].wr), 32'd0);
    end
    check("A_latency", 32'(td - ts), 32'd3);

    // Simultaneous requests: data store first, fetch right after dm_done.
    fixed_lat = 2;
    n0 = iss_log.size();
    fork
      fetch_xact(16'h0020, init_val(16'h0020), 1'b0, 0, ts_f, td_f);
      dm_xact(1'b1, 16'h0010, 16'h1234, 0, ts_d, td_d);
    join
    check("B_issue_count", 32'(iss_log.size()), 32'(n0 + 2));
    if (iss_log.size() == n0 + 2) begin
      check("B_first_wr", 32'(iss_log[n0].wr), 32'd1);
      check("B_first_addr", 32'(iss_log[n0].addr), 32'h0010);
      check("B_first_wdata", 32'(iss_log[n0].wdata), 32'h1234);
      check("B_second_addr", 32'(iss_log[n0 + 1].addr), 32'h0020);
      check("B_second_cyc", 32'(iss_log[n0 + 1].cyc), 32'(td_d + 1));
    end
    check("B_fetch_done", 32'(td_f), 32'(td_d + 3));
    dm_xact(1'b0, 16'h0010, 16'h0000, 0, ts, td);

    // Continuous data with fetch pending: starvation bound.
    fixed_lat = 1;
    n0 = iss_log.size();
    fork
      begin repeat (3) fetch_xact(16'h0040, init_val(16'h0040), 1'b0, 0, ts_f, td_f); end
      begin repeat (12) dm_xact(1'b0, 16'h0100, 16'h0000, 0, ts_d, td_d); end
    join
    check("C_issue_count", 32'(iss_log.size()), 32'(n0 + 15));
    nd = 12; nf = 3; streak = 0;
    for (int k = 0; k < 15; k++) begin
      if (nd > 0 && (nf == 0 || streak < int'(STARVE_MAX))) begin
        exp_fetch = 1'b0; nd--;
        if (nf > 0) streak++;
      end else begin
        exp_fetch = 1'b1; nf--; streak = 0;
      end
      if (n0 + k < iss_log.size())
        check("C_grant_order", 32'(iss_log[n0 + k].addr == 16'h0040), 32'(exp_fetch));
    end

    // Misaligned data: zero latency, no memory issue.
    n0 = iss_log.size();
    dm_xact(1'b0, 16'h0011, 16'h0000, 0, ts, td);
    check("D_zero_latency", 32'(td), 32'(ts));
    check("D_no_issue", 32'(iss_log.size()), 32'(n0));

    // Silent memory: timeout, then a stray completion is ignored.
    mute = 1'b1;
    n0 = iss_log.size();
    fetch_xact(16'h0030, 16'h0000, 1'b1, 0, ts, td);
    check("E_timeout_latency", 32'(td - ts), 32'(TIMEOUT));
    if (iss_log.size() == n0 + 1) check("E_issue_cyc", 32'(iss_log[n0].cyc), 32'(ts));
    mute = 1'b0;
    nd0 = n_if_done + n_dm_done;
    n0 = iss_log.size();
    stray_n++;
    repeat (3) begin @(posedge clk); #1; end
    check("E_stray_no_done", 32'(n_if_done + n_dm_done), 32'(nd0));
    check("E_stray_no_issue", 32'(iss_log.size()), 32'(n0));
    fetch_xact(16'h0032, init_val(16'h0032), 1'b0, 0, ts, td);

    // Reset while data is outstanding: abort silently, then retry.
    mute = 1'b1;
    n0 = iss_log.size();
    nd0 = n_dm_done;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0120; dm_wdata = '0;
    repeat (3) begin @(posedge clk); #1; end
    check("F_issued", 32'(iss_log.size()), 32'(n0 + 1));
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    dm_req = 1'b0; dm_addr = '0;
    mute = 1'b0;
    check("F_no_done", 32'(n_dm_done), 32'(nd0));
    @(posedge clk); #1;
    dm_xact(1'b0, 16'h0120, 16'h0000, 0, ts, td);

    // Randomised traffic with busy memory and variable latency.
    busy_rand = 1'b1;
    rand_lat  = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          fa = 16'h0080 | (16'($urandom_range(0, 63)) << 1);
          if ($urandom_range(0, 7) == 0) fa[0] = 1'b1;
          fetch_xact(fa, init_val(fa), 1'b0, int'($urandom_range(0, 3)), ts2, td2);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          da = 16'h0100 | (16'($urandom_range(0, 15)) << 1);
          if ($urandom_range(0, 7) == 0) da[0] = 1'b1;
          dw = 1'($urandom_range(0, 1));
          dm_xact(dw, da, 16'($urandom), int'($urandom_range(0, 3)), ts3, td3);
        end
      end
    join
    busy_rand = 1'b0;
    rand_lat  = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    check("dm_queue_drained", 32'(dm_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, variable-latency 16-bit memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 16-bit pipeline. It serialises requests, keeps at most one transaction outstanding, and gives data accesses priority with a starvation bound for fetch. It also flags misaligned accesses and unresponsive memory back to the requester.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while fetch waits; 0 = strict data priority.
- TIMEOUT, 64: cycles to wait for mem_done before aborting.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_done.
- if_addr  in  16  fetch address; stable while if_req.
- if_done  out  1  one-cycle completion pulse to fetch.
- if_rdata  out  16  instruction word; valid only with if_done, else 0.
- if_err  out  1  with if_done: misaligned or timeout.
- if_stall  out  1  if_req & ~if_done.
- dm_req  in  1  data request; held until dm_done.
- dm_wr  in  1  1 = store, 0 = load; stable while dm_req.
- dm_addr  in  16  data address; stable while dm_req.
- dm_wdata  in  16  store data; stable while dm_req.
- dm_done, dm_rdata, dm_err, dm_stall: data-side equivalents of the fetch outputs (dm_rdata 0 for stores).
- mem_en  out  1  one-cycle issue strobe.
- mem_wr  out  1  write qualifier for mem_en.
- mem_addr  out  16  issue address.
- mem_wdata  out  16  issue write data.
- mem_busy  in  1  memory cannot accept; mem_en never asserted while high.
- mem_done  in  1  one-cycle completion from memory.
- mem_rdata  in  16  read data, valid with mem_done.

## Operation
- States: IDLE, IF_BUSY, DM_BUSY. Reset → IDLE, starve_cnt = 0, timer = 0.
- IDLE winner selection (only when mem_busy = 0): dm_req alone → data; if_req alone → fetch; both → data unless STARVE_MAX ≠ 0 and starve_cnt == STARVE_MAX, then fetch.
- starve_cnt: +1 on each data grant while if_req is high; cleared on any fetch grant; saturates at STARVE_MAX.
- Misaligned winner (addr[0] = 1): no mem_en; requester's done and err pulse in that same cycle; rdata 0; stay IDLE. This counts as a grant for starve_cnt.
- Aligned winner: mem_en = 1 with mem_wr/addr/wdata from winner (mem_wr = 0 for fetch); next state IF_BUSY or DM_BUSY; timer cleared.
- *_BUSY: mem_en = 0; timer +1 per cycle. On mem_done: owner's done pulses, rdata = mem_rdata (loads/fetch), err = 0, → IDLE. If timer reaches TIMEOUT−1 with no mem_done: owner's done and err pulse, → IDLE.
- mem_done in IDLE: ignored (stale completion after reset or timeout).
- mem_addr/mem_wdata/mem_wr are 0 whenever mem_en = 0.
- All outputs 0 during and after reset, except stall, which follows req.

## Timing
- done/rdata/err are combinational from mem_done in the BUSY state. Issue cycle t, mem_done at t+k (k ≥ 1) → done at t+k; earliest next issue t+k+1.
- Misaligned: done/err in the request's first IDLE cycle (zero latency).
- Timeout: done/err exactly TIMEOUT cycles after issue.
- rst asserted in any state: IDLE on the next edge, no done pulse for the aborted request; the requester re-requests.
- Requests arriving while BUSY wait; they are arbitrated in the first IDLE cycle.

## Structure
- Shared package mem_arb_pkg: state encoding localparams (IDLE = 2'd0, IF_BUSY = 2'd1, DM_BUSY = 2'd2) and default STARVE_MAX/TIMEOUT constants.
- One sub-module: mem_arb_timer. It holds a clear/enable counter with an expiry flag, parameterised by TIMEOUT.

## Test plan
- Lone fetch, if_addr = 0x0004, memory done after 3 cycles with 0xA5C3 → mem_en at t, if_done with if_rdata = 0xA5C3 at t+3, if_err = 0.
- Simultaneous if_req and dm_req (store 0x1234 to 0x0010), STARVE_MAX = 4 → data issued first with mem_wr = 1; fetch issued the cycle after dm_done.
- dm_req held continuously with if_req pending → exactly 4 data grants, then 1 fetch grant, then the pattern repeats.
- dm_addr = 0x0011 → dm_done and dm_err in the same cycle, mem_en never asserted.
- Memory never responds, TIMEOUT = 64 → if_done and if_err at issue+64; a later stray mem_done is ignored.
- rst pulsed while in DM_BUSY → IDLE, no dm_done; all outputs 0; the re-issued request completes normally.
